// File: rtl/bp_seq_pkg.sv
// Shared types for the branch-predictor outcome sequencer: FSM state encoding,
// default PC width and the queued branch record layout.
package bp_seq_pkg;

    localparam int PC_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREDICT = 2'd1,
        ST_UPDATE  = 2'd2
    } bp_seq_state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic                taken;
    } bp_seq_rec_t;

endpackage

// File: rtl/bp_seq_fifo.sv
// Synchronous FIFO with async reset, full/empty flags and occupancy count.
// A word pushed into an empty FIFO becomes visible on the following cycle.
module bp_seq_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bp_outcome_sequencer.sv
// Initiator for the local predictor update port: queues resolved branches,
// presents each PC for PRED_LAT cycles, drives the outcome for HOLD cycles, retires.
module bp_outcome_sequencer
    import bp_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int DEPTH    = 8,
    parameter int PRED_LAT = 4,
    parameter int HOLD     = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             in_taken,
    output logic             in_ready,
    output logic [PC_W-1:0]  PC,
    output logic             BranchTaken,
    output logic             bt_valid,
    input  logic             LDresult,
    output logic             done,
    output logic [PC_W-1:0]  done_pc,
    output logic             done_correct,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             busy
);
    localparam int PH_MAX = (PRED_LAT > HOLD) ? PRED_LAT : HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  PRED_LAST = PH_W'(PRED_LAT - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    bp_seq_state_t     state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              cur_taken_q, cur_taken_d;
    logic              pred_q, pred_d;
    logic              bt_q, bt_d;
    logic              bt_valid_q, bt_valid_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   done_pc_q, done_pc_d;
    logic              done_correct_q, done_correct_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

    logic              fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [PC_W:0]     fifo_rdata_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    bp_seq_fifo #(.W(PC_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .wdata ({in_pc, in_taken}),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign in_ready       = !fifo_full_s;
    assign busy           = (state_q != ST_IDLE) || (fifo_count_s != '0);
    assign PC             = pc_q;
    assign BranchTaken    = bt_q;
    assign bt_valid       = bt_valid_q;
    assign done           = done_q;
    assign done_pc        = done_pc_q;
    assign done_correct   = done_correct_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mis_cnt_q;

    // Phase sequencing; interface outputs are registered so they line up with the phase.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        pc_d           = pc_q;
        cur_taken_d    = cur_taken_q;
        pred_d         = pred_q;
        bt_d           = 1'b0;
        bt_valid_d     = 1'b0;
        done_d         = 1'b0;
        done_pc_d      = done_pc_q;
        done_correct_d = done_correct_q;
        branch_cnt_d   = branch_cnt_q;
        mis_cnt_d      = mis_cnt_q;
        fifo_pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    pc_d        = fifo_rdata_s[PC_W:1];
                    cur_taken_d = fifo_rdata_s[0];
                    phase_d     = '0;
                    state_d     = ST_PREDICT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREDICT: begin
                if (phase_q == PRED_LAST) begin
                    pred_d     = LDresult;
                    phase_d    = '0;
                    state_d    = ST_UPDATE;
                    bt_valid_d = 1'b1;
                    bt_d       = cur_taken_q;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                if (phase_q == HOLD_LAST) begin
                    done_d         = 1'b1;
                    done_pc_d      = pc_q;
                    done_correct_d = (pred_q == cur_taken_q);
                    branch_cnt_d   = (branch_cnt_q == CNT_MAX) ? branch_cnt_q : branch_cnt_q + 1'b1;
                    if (pred_q != cur_taken_q) begin
                        mis_cnt_d = (mis_cnt_q == CNT_MAX) ? mis_cnt_q : mis_cnt_q + 1'b1;
                    end else begin
                        mis_cnt_d = mis_cnt_q;
                    end
                    // Back-to-back: the next record starts without an IDLE bubble.
                    if (!fifo_empty_s) begin
                        fifo_pop_s  = 1'b1;
                        pc_d        = fifo_rdata_s[PC_W:1];
                        cur_taken_d = fifo_rdata_s[0];
                        phase_d     = '0;
                        state_d     = ST_PREDICT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    phase_d    = phase_q + 1'b1;
                    bt_valid_d = 1'b1;
                    bt_d       = cur_taken_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, interface outputs and statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            pc_q           <= '0;
            cur_taken_q    <= 1'b0;
            pred_q         <= 1'b0;
            bt_q           <= 1'b0;
            bt_valid_q     <= 1'b0;
            done_q         <= 1'b0;
            done_pc_q      <= '0;
            done_correct_q <= 1'b0;
            branch_cnt_q   <= '0;
            mis_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            pc_q           <= pc_d;
            cur_taken_q    <= cur_taken_d;
            pred_q         <= pred_d;
            bt_q           <= bt_d;
            bt_valid_q     <= bt_valid_d;
            done_q         <= done_d;
            done_pc_q      <= done_pc_d;
            done_correct_q <= done_correct_d;
            branch_cnt_q   <= branch_cnt_d;
            mis_cnt_q      <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_outcome_sequencer.sv
// Self-checking bench: a timeline model (accept/pop/retire edges per branch)
// predicts every output each cycle; a CNT_W=2 twin checks counter saturation.
module tb_bp_outcome_sequencer;
    import bp_seq_pkg::*;

    localparam int PC_W     = 10;
    localparam int DEPTH    = 8;
    localparam int PRED_LAT = 4;
    localparam int HOLD     = 4;
    localparam int CNT_W    = 16;
    localparam int SAT_W    = 2;
    localparam int LAT      = PRED_LAT + HOLD;
    localparam int MAXR     = 64;

    logic clock = 1'b0;
    logic reset;
    logic in_valid, in_taken;
    logic [PC_W-1:0] in_pc;
    logic in_ready, bt_o, btv_o, done_o, done_correct_o, busy_o, ld_result;
    logic [PC_W-1:0] pc_o, done_pc_o;
    logic [CNT_W-1:0] branch_cnt_o, mis_cnt_o;
    logic in_ready_s, bt_s, btv_s, done_s, done_correct_s, busy_s, ld_result_s;
    logic [PC_W-1:0] pc_s, done_pc_s;
    logic [SAT_W-1:0] branch_cnt_s, mis_cnt_s;

    int ld_mode = 1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Timeline model: one entry per accepted branch, in acceptance order.
    int n_rec = 0;
    int prev_ret = 0;
    int r_acc [MAXR];
    int r_pop [MAXR];
    int r_ret [MAXR];
    logic [PC_W-1:0] r_pc [MAXR];
    logic r_taken [MAXR];
    logic r_pred [MAXR];

    always #5 clock = ~clock;

    function automatic logic pred_fn(input logic [PC_W-1:0] pc, input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return ^(pc ^ 10'h2A5);
        endcase
    endfunction

    assign ld_result   = pred_fn(pc_o, ld_mode);
    assign ld_result_s = pred_fn(pc_s, ld_mode);

    bp_outcome_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH), .PRED_LAT(PRED_LAT), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_taken(in_taken),
        .in_ready(in_ready), .PC(pc_o), .BranchTaken(bt_o), .bt_valid(btv_o), .LDresult(ld_result),
        .done(done_o), .done_pc(done_pc_o), .done_correct(done_correct_o),
        .branch_cnt(branch_cnt_o), .mispredict_cnt(mis_cnt_o), .busy(busy_o));

    bp_outcome_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH), .PRED_LAT(PRED_LAT), .HOLD(HOLD), .CNT_W(SAT_W)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_taken(in_taken),
        .in_ready(in_ready_s), .PC(pc_s), .BranchTaken(bt_s), .bt_valid(btv_s), .LDresult(ld_result_s),
        .done(done_s), .done_pc(done_pc_s), .done_correct(done_correct_s),
        .branch_cnt(branch_cnt_s), .mispredict_cnt(mis_cnt_s), .busy(busy_s));

    function automatic int model_occ(input int k);
        int occ = 0;
        for (int i = 0; i < n_rec; i++) begin
            if (r_acc[i] <= k && r_pop[i] > k) occ++;
        end
        return occ;
    endfunction

    // Advance one edge and compare every output with the timeline model.
    task automatic tick();
        int occ, ret_n, mis_n;
        logic e_busy, e_btv, e_bt, e_done, e_dc, e_ready;
        logic [PC_W-1:0] e_pc, e_dpc;
        logic [SAT_W-1:0] e_sbc, e_smc;
        @(posedge clock);
        cyc++;
        #1;
        occ = model_occ(cyc);
        ret_n = 0; mis_n = 0;
        e_busy = 1'b0; e_btv = 1'b0; e_bt = 1'b0; e_done = 1'b0; e_dc = 1'b0;
        e_pc = '0; e_dpc = '0;
        for (int i = 0; i < n_rec; i++) begin
            if (r_pop[i] <= cyc) e_pc = r_pc[i];
            if (r_pop[i] <= cyc && cyc < r_ret[i]) begin
                e_busy = 1'b1;
                if (cyc - r_pop[i] >= PRED_LAT) begin
                    e_btv = 1'b1;
                    e_bt  = r_taken[i];
                end
            end
            if (r_ret[i] <= cyc) begin
                ret_n++;
                if (r_pred[i] != r_taken[i]) mis_n++;
                e_dpc = r_pc[i];
                e_dc  = (r_pred[i] == r_taken[i]);
            end
            if (r_ret[i] == cyc) e_done = 1'b1;
        end
        e_ready = (occ < DEPTH);
        e_busy  = e_busy || (occ > 0);
        e_sbc   = (ret_n > 3) ? 2'd3 : SAT_W'(ret_n);
        e_smc   = (mis_n > 3) ? 2'd3 : SAT_W'(mis_n);
        checks++; if (in_ready !== e_ready) begin failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_ready); end
        checks++; if (busy_o !== e_busy) begin failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, e_busy); end
        checks++; if (pc_o !== e_pc) begin failures++; $display("FAIL PC cyc=%0d got=%0d exp=%0d", cyc, pc_o, e_pc); end
        checks++; if (btv_o !== e_btv) begin failures++; $display("FAIL bt_valid cyc=%0d got=%b exp=%b", cyc, btv_o, e_btv); end
        checks++; if (bt_o !== e_bt) begin failures++; $display("FAIL BranchTaken cyc=%0d got=%b exp=%b", cyc, bt_o, e_bt); end
        checks++; if (done_o !== e_done) begin failures++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, e_done); end
        checks++; if (done_pc_o !== e_dpc) begin failures++; $display("FAIL done_pc cyc=%0d got=%0d exp=%0d", cyc, done_pc_o, e_dpc); end
        checks++; if (done_correct_o !== e_dc) begin failures++; $display("FAIL done_correct cyc=%0d got=%b exp=%b", cyc, done_correct_o, e_dc); end
        checks++; if (branch_cnt_o !== CNT_W'(ret_n)) begin failures++; $display("FAIL branch_cnt cyc=%0d got=%0d exp=%0d", cyc, branch_cnt_o, ret_n); end
        checks++; if (mis_cnt_o !== CNT_W'(mis_n)) begin failures++; $display("FAIL mispredict_cnt cyc=%0d got=%0d exp=%0d", cyc, mis_cnt_o, mis_n); end
        checks++;
        if (branch_cnt_s !== e_sbc || mis_cnt_s !== e_smc || done_s !== e_done || pc_s !== e_pc ||
            btv_s !== e_btv || bt_s !== e_bt || done_pc_s !== e_dpc || done_correct_s !== e_dc ||
            in_ready_s !== e_ready || busy_s !== e_busy) begin
            failures++;
            $display("FAIL sat_twin cyc=%0d got bc=%0d mc=%0d done=%b exp bc=%0d mc=%0d done=%b",
                     cyc, branch_cnt_s, mis_cnt_s, done_s, e_sbc, e_smc, e_done);
        end
    endtask

    // Offer one record for the coming edge; the model decides acceptance from its own occupancy.
    task automatic push_cycle(input logic v, input logic [PC_W-1:0] pc, input logic tk, output logic accepted);
        in_valid = v; in_pc = pc; in_taken = tk;
        accepted = 1'b0;
        if (v && model_occ(cyc) < DEPTH && n_rec < MAXR) begin
            r_acc[n_rec]   = cyc + 1;
            r_pop[n_rec]   = (cyc + 2 > prev_ret) ? cyc + 2 : prev_ret;
            r_ret[n_rec]   = r_pop[n_rec] + LAT;
            r_pc[n_rec]    = pc;
            r_taken[n_rec] = tk;
            r_pred[n_rec]  = pred_fn(pc, ld_mode);
            prev_ret       = r_ret[n_rec];
            n_rec++;
            accepted = 1'b1;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && cyc <= prev_ret; t++) tick();
        checks++;
        if (cyc <= prev_ret) begin failures++; $display("FAIL drain_timeout cyc=%0d last_retire=%0d", cyc, prev_ret); end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_pc = '0; in_taken = 1'b0;
        reset = 1'b1;
        @(posedge clock); cyc++;
        @(posedge clock); cyc++;
        #1;
        reset = 1'b0;
        n_rec = 0;
        prev_ret = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'bx; in_pc = 'x; in_taken = 1'bx;
        repeat (16) begin @(posedge clock); cyc++; end
        #1;
        checks++; if (in_ready !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL reset_flags in_ready=%b busy=%b exp 1/0", in_ready, busy_o); end
        checks++; if (pc_o !== '0 || bt_o !== 1'b0 || btv_o !== 1'b0) begin failures++; $display("FAIL reset_iface PC=%0d bt=%b btv=%b exp 0", pc_o, bt_o, btv_o); end
        checks++; if (done_o !== 1'b0 || done_pc_o !== '0 || done_correct_o !== 1'b0) begin failures++; $display("FAIL reset_done done=%b pc=%0d ok=%b exp 0", done_o, done_pc_o, done_correct_o); end
        checks++; if (branch_cnt_o !== '0 || mis_cnt_o !== '0 || branch_cnt_s !== '0) begin failures++; $display("FAIL reset_cnt bc=%0d mc=%0d exp 0", branch_cnt_o, mis_cnt_o); end
        in_valid = 1'b0; in_pc = '0; in_taken = 1'b0;
        reset = 1'b0;
        n_rec = 0; prev_ret = 0;
    endtask

    task automatic test_single();
        logic acc;
        int e0, pred_n, upd_n, done_edge;
        ld_mode = 1;
        e0 = cyc + 1; pred_n = 0; upd_n = 0; done_edge = -1;
        push_cycle(1'b1, 10'd5, 1'b1, acc);
        repeat (11) begin
            tick();
            if (pc_o == 10'd5 && !btv_o && busy_o) pred_n++;
            if (btv_o && bt_o) upd_n++;
            if (done_o) done_edge = cyc;
        end
        checks++; if (pred_n != PRED_LAT) begin failures++; $display("FAIL single_predict_cycles got=%0d exp=%0d", pred_n, PRED_LAT); end
        checks++; if (upd_n != HOLD) begin failures++; $display("FAIL single_update_cycles got=%0d exp=%0d", upd_n, HOLD); end
        checks++; if (done_edge != e0 + 9) begin failures++; $display("FAIL single_done_edge got=%0d exp=%0d", done_edge, e0 + 9); end
        checks++; if (done_pc_o !== 10'd5 || done_correct_o !== 1'b1 || branch_cnt_o !== 16'd1 || mis_cnt_o !== 16'd0) begin
            failures++; $display("FAIL single_retire pc=%0d ok=%b bc=%0d mc=%0d exp 5/1/1/0", done_pc_o, done_correct_o, branch_cnt_o, mis_cnt_o); end
    endtask

    task automatic test_mispredict();
        logic acc;
        ld_mode = 0;
        push_cycle(1'b1, 10'd3, 1'b1, acc);
        drain();
        checks++; if (done_correct_o !== 1'b0 || done_pc_o !== 10'd3 || mis_cnt_o !== 16'd1) begin
            failures++; $display("FAIL mispredict ok=%b pc=%0d mc=%0d exp 0/3/1", done_correct_o, done_pc_o, mis_cnt_o); end
    endtask

    task automatic test_stream();
        logic acc, saw_full;
        int p, n_done, last_edge;
        do_reset();
        ld_mode = 2; p = 0; n_done = 0; last_edge = -1; saw_full = 1'b0;
        for (int t = 0; t < 400 && (p < 11 || cyc <= prev_ret); t++) begin
            if (!in_ready) saw_full = 1'b1;
            if (p < 11) begin
                push_cycle(1'b1, PC_W'(p), 1'b1, acc);
                if (acc) p++;
            end else begin
                tick();
            end
            if (done_o) begin
                checks++; if (done_pc_o !== PC_W'(n_done)) begin failures++; $display("FAIL stream_order got=%0d exp=%0d", done_pc_o, n_done); end
                if (last_edge >= 0) begin
                    checks++; if (cyc - last_edge != LAT) begin failures++; $display("FAIL stream_spacing got=%0d exp=%0d", cyc - last_edge, LAT); end
                end
                last_edge = cyc;
                n_done++;
            end
        end
        checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL stream_in_ready_drop got=%b exp=1", saw_full); end
        checks++; if (n_done != 11 || branch_cnt_o !== 16'd11) begin failures++; $display("FAIL stream_count done=%0d bc=%0d exp 11", n_done, branch_cnt_o); end
    endtask

    task automatic test_random();
        logic acc;
        ld_mode = 2;
        for (int t = 0; t < 48; t++) begin
            push_cycle(1'($urandom_range(0, 1)), PC_W'($urandom), 1'($urandom), acc);
        end
        drain();
        checks++; if (branch_cnt_o !== CNT_W'(n_rec)) begin failures++; $display("FAIL random_total got=%0d exp=%0d", branch_cnt_o, n_rec); end
    endtask

    task automatic test_reset_mid();
        logic acc, saw_done;
        do_reset();
        ld_mode = 2;
        for (int i = 0; i < 4; i++) push_cycle(1'b1, PC_W'(100 + i), 1'(i), acc);
        repeat (3) tick();
        checks++; if (btv_o !== 1'b1) begin failures++; $display("FAIL mid_in_update btv=%b exp=1", btv_o); end
        reset = 1'b1;
        #1;
        checks++; if (done_o !== 1'b0 || branch_cnt_o !== '0 || busy_o !== 1'b0 || in_ready !== 1'b1 || btv_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset done=%b bc=%0d busy=%b rdy=%b btv=%b", done_o, branch_cnt_o, busy_o, in_ready, btv_o); end
        @(posedge clock); cyc++;
        @(posedge clock); cyc++;
        #1;
        reset = 1'b0;
        n_rec = 0; prev_ret = 0; saw_done = 1'b0;
        repeat (12) begin tick(); if (done_o) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%b exp=0", saw_done); end
        push_cycle(1'b1, 10'd7, 1'b1, acc);
        drain();
        checks++; if (done_pc_o !== 10'd7 || branch_cnt_o !== 16'd1) begin failures++; $display("FAIL mid_recover pc=%0d bc=%0d exp 7/1", done_pc_o, branch_cnt_o); end
    endtask

    task automatic test_saturation();
        logic acc;
        do_reset();
        ld_mode = 0;
        for (int i = 0; i < 5; i++) push_cycle(1'b1, PC_W'(20 + i), 1'b1, acc);
        drain();
        checks++; if (branch_cnt_s !== 2'd3 || mis_cnt_s !== 2'd3) begin failures++; $display("FAIL saturation bc=%0d mc=%0d exp 3/3", branch_cnt_s, mis_cnt_s); end
        checks++; if (branch_cnt_o !== 16'd5 || mis_cnt_o !== 16'd5) begin failures++; $display("FAIL wide_counts bc=%0d mc=%0d exp 5/5", branch_cnt_o, mis_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mispredict();
        test_stream();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_outcome_sequencer.md
# bp_outcome_sequencer

Drives the update side of the local branch predictor (`LocalDesign`). It accepts resolved branch records (PC, actual outcome) through a small FIFO and presents each PC to the predictor for a fixed prediction window. It samples the predictor's result, then drives the actual outcome for a fixed update window. It retires each branch with a correct/mispredict report and keeps running branch and mispredict counters. This block is the initiator end of the interface the predictor responds to.

## Interface
Parameters:
- `PC_W`, 10, PC width presented to the predictor
- `DEPTH`, 8, input FIFO entries (power of two, ≥2)
- `PRED_LAT`, 4, cycles PC is held before the prediction is sampled (≥1)
- `HOLD`, 4, cycles the actual outcome is driven (≥1)
- `CNT_W`, 16, statistics counter width

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: branch record offered
- `in_pc` in PC_W: branch PC
- `in_taken` in 1: resolved outcome
- `in_ready` out 1: FIFO not full
- `PC` out PC_W: PC to predictor
- `BranchTaken` out 1: outcome to predictor; 0 when `bt_valid`=0
- `bt_valid` out 1: `BranchTaken` is meaningful (UPDATE phase)
- `LDresult` in 1: predictor output
- `done` out 1: one-cycle retire pulse
- `done_pc` out PC_W: PC of the retired branch
- `done_correct` out 1: prediction matched the outcome
- `branch_cnt` out CNT_W: branches retired, saturating
- `mispredict_cnt` out CNT_W: mispredictions, saturating
- `busy` out 1: state ≠ IDLE or FIFO not empty

## Operation
- FIFO: push on `in_valid && in_ready`; `in_ready = !full`. No bypass: a record pushed into an empty FIFO is poppable the next cycle. Order is strictly FIFO.
- FSM states: IDLE, PREDICT, UPDATE.
- IDLE: if the FIFO is non-empty, pop into `cur_pc`/`cur_taken`, clear the phase counter, and go to PREDICT.
- PREDICT, lasting PRED_LAT cycles:
  - `PC=cur_pc`, `bt_valid=0`, `BranchTaken=0`.
  - At the edge ending the last PREDICT cycle, capture `LDresult` into `pred_q`, clear the counter, and go to UPDATE.
- UPDATE, lasting HOLD cycles:
  - `PC=cur_pc`, `bt_valid=1`, `BranchTaken=cur_taken`.
  - At the edge ending the last UPDATE cycle, retire: register `done=1`, `done_pc=cur_pc`, `done_correct=(pred_q==cur_taken)`.
  - Increment `branch_cnt`. Increment `mispredict_cnt` if the prediction was incorrect.
  - If the FIFO is non-empty at the same edge, pop the next record and go straight to PREDICT (back-to-back). Otherwise go to IDLE.
- Counters saturate at all-ones and never wrap.
- In IDLE, `PC` holds its last value (0 after reset).
- Push while full is ignored, because `in_ready` is low. Push and pop in the same cycle are both honoured; occupancy is unchanged.

## Timing
- Reset values: state IDLE, FIFO empty, `in_ready=1`, `PC=0`, `BranchTaken=0`, `bt_valid=0`, `done=0`, `done_pc=0`, `done_correct=0`, both counters 0, `busy=0`.
- Reset mid-operation: the in-flight branch and FIFO contents are discarded and no `done` is issued. The counters clear.
- Single branch into an idle, empty block: accepted at edge E0, popped at E1, PREDICT for E1..E1+PRED_LAT, UPDATE for the next HOLD cycles. `done` is high for one cycle after edge E1+PRED_LAT+HOLD (E9 with defaults).
- Back-to-back steady state: one branch per PRED_LAT+HOLD cycles (8 with defaults), with no IDLE bubble between branches.
- `done`/`done_*` and the counters update on the same edge. `done_pc`/`done_correct` hold until the next retire.

## Structure
- Package `bp_seq_pkg`: the state enum `bp_seq_state_t` (IDLE, PREDICT, UPDATE), the default `PC_W`, and the record struct `{pc, taken}`.
- Sub-module `bp_seq_fifo`: parameterised synchronous FIFO with async reset, `full`/`empty` flags, and an occupancy count. The FSM, phase counter, and statistics live in the top module.

## Test plan
- Reset: assert `reset` for 16 cycles with X on the inputs. Required: every output at its reset value, `in_ready=1`, `busy=0`.
- Single branch: use a stub predictor with `LDresult=1`; push pc=5, taken=1. Required:
  - `PC=5` with `bt_valid=0` for 4 cycles.
  - `BranchTaken=1` with `bt_valid=1` for 4 cycles.
  - A `done` pulse at E9 with `done_pc=5` and `done_correct=1`; `branch_cnt=1`, `mispredict_cnt=0`.
- Mispredict: stub `LDresult=0`; push pc=3, taken=1. Required: `done_correct=0`, `mispredict_cnt=1`.
- Stream: push pc 0..10 (all taken) at one per cycle against the real `LocalDesign`. Required:
  - `in_ready` drops when DEPTH entries are pending.
  - Retires arrive in order, 8 cycles apart.
  - `branch_cnt=11` at the end.
- Reset mid-UPDATE: assert `reset` with 3 entries queued. Required: no `done`, counters 0, FIFO empty. A subsequent push of pc=7 completes normally.
- Saturation: with `CNT_W=2`, retire 5 mispredicted branches. Required: both counters hold at 3.
